// File: rtl/ahb3lite_interconnect_slave_arbiter_pkg.sv
// Shared AHB3-Lite switch types, priority limits and the one-hot to binary encoder.
// Pure declarations: no latency, no flow control.
package ahb3lite_pkg;

    localparam int   PRIO_W    = 3;
    localparam logic [PRIO_W-1:0] HPRIO_MAX = 3'd7;

    // Encoder width covers every master/slave count the switch is built with.
    localparam int   OH_MAX_W  = 32;
    localparam int   BIN_W     = 5;

    typedef logic [PRIO_W-1:0] hprio_t;

    // OR-reduction encoder: exact for one-hot input, zero for an all-zero vector.
    function automatic logic [BIN_W-1:0] onehot2bin(input logic [OH_MAX_W-1:0] oh);
        logic [BIN_W-1:0] b;
        b = '0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                b = b | BIN_W'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ahb3lite_interconnect_slave_arbiter_if.sv
// Request/grant bundle between the master ports and one slave-port arbiter.
// Wires only: no latency; backpressure is carried by slv_HREADY.
interface ahb3lite_interconnect_slave_arbiter_if #(
    parameter  int MASTERS     = 3,
    localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) ();
    import ahb3lite_pkg::*;

    logic   [MASTERS-1:0]     mst_HSEL;
    hprio_t [MASTERS-1:0]     mst_priority;
    logic   [MASTERS-1:0]     mst_can_switch;
    logic                     slv_HREADY;
    logic   [MASTERS-1:0]     master_granted;
    logic   [MASTER_BITS-1:0] master_sel;
    logic                     grant_valid;

    modport master (
        output mst_HSEL, mst_priority, mst_can_switch, slv_HREADY,
        input  master_granted, master_sel, grant_valid
    );

    modport slave (
        input  mst_HSEL, mst_priority, mst_can_switch, slv_HREADY,
        output master_granted, master_sel, grant_valid
    );

endinterface

// File: rtl/ahb3lite_interconnect_slave_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping, ptr last.
// Zero latency; no flow control (gnt is all-zero when req is all-zero).
module ahb3lite_interconnect_rr_pick
    import ahb3lite_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic              found;
    logic [PW-1:0]     j;
    logic [BIN_W-1:0]  idx_full;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        idx_full = onehot2bin(OH_MAX_W'(gnt));
        gnt_idx  = idx_full[PW-1:0];
    end

endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave arbiter: highest-priority requester wins, ties rotate round-robin; grant registered.
// One-cycle request-to-grant latency; grant frozen while slv_HREADY is low or the owner forbids a switch.
module ahb3lite_interconnect_slave_arbiter
    import ahb3lite_pkg::*;
#(
    parameter  int MASTERS     = 3,
    localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb3lite_interconnect_slave_arbiter_if.slave bus
);

    logic [MASTERS-1:0]     owner_q,  owner_d;
    logic [MASTER_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [MASTER_BITS-1:0] sel_q,    sel_d;

    hprio_t                 max_prio;
    logic [MASTERS-1:0]     cand;
    logic [MASTERS-1:0]     win_oh;
    logic [MASTER_BITS-1:0] win_idx;

    logic grant_valid;
    logic owner_req;
    logic owner_cs;
    logic any_req;
    logic sw;

    // Only requesters take part in the maximum, so an idle high-priority port cannot mask others.
    always_comb begin
        max_prio = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (bus.mst_HSEL[m] && (bus.mst_priority[m] > max_prio)) begin
                max_prio = bus.mst_priority[m];
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int m = 0; m < MASTERS; m++) begin
            cand[m] = bus.mst_HSEL[m] && (bus.mst_priority[m] == max_prio);
        end
    end

    ahb3lite_interconnect_rr_pick #(
        .N (MASTERS)
    ) u_rr_pick (
        .req     (cand),
        .ptr     (rr_ptr_q),
        .gnt     (win_oh),
        .gnt_idx (win_idx)
    );

    assign grant_valid = |owner_q;
    assign owner_req   = |(owner_q & bus.mst_HSEL);
    assign owner_cs    = |(owner_q & bus.mst_can_switch);
    assign any_req     = |bus.mst_HSEL;
    assign sw          = bus.slv_HREADY & (~grant_valid | ~owner_req | owner_cs);

    // With no requester the bus parks: ownership drops but the select keeps the last owner.
    always_comb begin
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        if (sw) begin
            if (any_req) begin
                owner_d  = win_oh;
                rr_ptr_d = win_idx;
                sel_d    = win_idx;
            end else begin
                owner_d  = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q  <= '0;
            rr_ptr_q <= MASTER_BITS'(MASTERS - 1);
            sel_q    <= '0;
        end else begin
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.master_granted = owner_q;
    assign bus.master_sel     = sel_q;
    assign bus.grant_valid    = grant_valid;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Directed bench for the per-slave arbiter with three master ports.
module tb_ahb3lite_interconnect_slave_arbiter;

    logic HCLK;
    logic HRESETn;
    int   tests;
    int   fails;

    ahb3lite_interconnect_slave_arbiter_if #(.MASTERS(3)) bus ();

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(3)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Grant must never be multi-hot.
    always @(negedge HCLK) begin
        tests++;
        if ($countones(bus.master_granted) > 1) begin
            fails++;
            $display("FAIL onehot: master_granted=%b required at most one bit set", bus.master_granted);
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic [2:0] exp_g, input logic [1:0] exp_s);
        tests++;
        if (bus.master_granted !== exp_g) begin
            fails++;
            $display("FAIL %s grant: got %b required %b", name, bus.master_granted, exp_g);
        end
        tests++;
        if (bus.master_sel !== exp_s) begin
            fails++;
            $display("FAIL %s sel: got %0d required %0d", name, bus.master_sel, exp_s);
        end
        tests++;
        if (bus.grant_valid !== (exp_g != 3'b000)) begin
            fails++;
            $display("FAIL %s valid: got %b required %b", name, bus.grant_valid, (exp_g != 3'b000));
        end
    endtask

    task automatic pulse_reset();
        HRESETn = 1'b0;
        #2;
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.mst_HSEL       = 3'b000;
        bus.mst_priority   = '0;
        bus.mst_can_switch = 3'b111;
        bus.slv_HREADY     = 1'b1;
        #12;
        chk_gnt("reset", 3'b000, 2'd0);
        HRESETn = 1'b1;
        step();
        chk_gnt("reset_idle", 3'b000, 2'd0);
    endtask

    task automatic test_single();
        bus.mst_HSEL        = 3'b010;
        bus.mst_priority[1] = 3'd2;
        step();
        chk_gnt("single_m1", 3'b010, 2'd1);
        bus.mst_HSEL = 3'b000;
        step();
        chk_gnt("park", 3'b000, 2'd1);
    endtask

    task automatic test_priority_back_to_back();
        bus.mst_HSEL        = 3'b101;
        bus.mst_priority[0] = 3'd1;
        bus.mst_priority[2] = 3'd5;
        step();
        chk_gnt("prio_m2", 3'b100, 2'd2);
        bus.mst_HSEL = 3'b001;
        step();
        chk_gnt("b2b_m0", 3'b001, 2'd0);
    endtask

    task automatic test_round_robin();
        bus.mst_HSEL = 3'b000;
        pulse_reset();
        bus.mst_priority   = {3'd3, 3'd3, 3'd3};
        bus.mst_can_switch = 3'b111;
        bus.mst_HSEL       = 3'b111;
        step(); chk_gnt("rr0", 3'b001, 2'd0);
        step(); chk_gnt("rr1", 3'b010, 2'd1);
        step(); chk_gnt("rr2", 3'b100, 2'd2);
        step(); chk_gnt("rr3", 3'b001, 2'd0);
    endtask

    task automatic test_lock();
        bus.mst_HSEL = 3'b010;
        step();
        chk_gnt("lock_own_m1", 3'b010, 2'd1);
        bus.mst_can_switch  = 3'b101;
        bus.mst_priority[0] = 3'd7;
        bus.mst_HSEL        = 3'b011;
        step(); chk_gnt("lock_hold_a", 3'b010, 2'd1);
        step(); chk_gnt("lock_hold_b", 3'b010, 2'd1);
        bus.mst_can_switch = 3'b111;
        step();
        chk_gnt("lock_release", 3'b001, 2'd0);
    endtask

    task automatic test_hready_stall();
        bus.slv_HREADY      = 1'b0;
        bus.mst_priority[0] = 3'd3;
        bus.mst_priority[2] = 3'd6;
        bus.mst_HSEL        = 3'b101;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_gnt($sformatf("stall_%0d", c), 3'b001, 2'd0);
        end
        bus.slv_HREADY = 1'b1;
        step();
        chk_gnt("stall_release", 3'b100, 2'd2);
    endtask

    task automatic test_reset_mid();
        bus.mst_priority[0] = 3'd4;
        bus.mst_priority[2] = 3'd4;
        bus.mst_HSEL        = 3'b101;
        #2;
        HRESETn = 1'b0;
        #1;
        chk_gnt("async_reset", 3'b000, 2'd0);
        #1;
        HRESETn = 1'b1;
        step();
        chk_gnt("post_reset_tie", 3'b001, 2'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_priority_back_to_back();
        test_round_robin();
        test_lock();
        test_hready_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb3lite_interconnect_slave_arbiter.md
# ahb3lite_interconnect_slave_arbiter

Per-slave arbiter of the AHB3-Lite multi-layer switch: one instance per slave port decides which master port owns that slave. It collects each master port's select request, 3-bit priority and `can_switch` indication, and produces the registered one-hot `master_granted` vector plus a binary select that steers the slave-side mux. Grants change only at AHB-legal switch points: the owner allows it and the slave is ready.

## Interface
- `MASTERS`, 3: number of master ports competing for this slave; at least 1.
- `MASTER_BITS`, `$clog2(MASTERS)` (1 when MASTERS==1): width of binary select. Local, not overridable.
---
- `HRESETn`  in  1  asynchronous active-low reset.
- `HCLK`  in  1  clock; all state changes on its rising edge.
- `mst_HSEL`  in  [MASTERS]  request: master port m's select bit for this slave.
- `mst_priority`  in  [MASTERS][3]  per-master priority; 7 highest, 0 lowest.
- `mst_can_switch`  in  [MASTERS]  master m permits losing ownership on the next edge.
- `slv_HREADY`  in  1  slave HREADYOUT.
- `master_granted`  out  [MASTERS]  one-hot (or zero) grant, registered.
- `master_sel`  out  MASTER_BITS  binary index of owner; holds last owner when idle (bus parking).
- `grant_valid`  out  1  |master_granted.

## Operation
- State: `owner` (one-hot register), `rr_ptr` (index of last winner), `master_sel`.
- Candidate set: requesting masters (`mst_HSEL[m]`) whose `mst_priority` equals the maximum priority among requesters.
- Winner: first candidate strictly after `rr_ptr`, searching upward with modulo-MASTERS wrap. `rr_ptr` is checked last, so a tie rotates fairly.
- Switch enable: `sw = slv_HREADY & (~grant_valid | ~mst_HSEL[owner] | mst_can_switch[owner])`.
- On each edge with `sw`:
  - If any request is present: `owner` ← winner, `rr_ptr` ← winner, `master_sel` ← winner.
  - If no request is present: `owner` ← 0. `master_sel` and `rr_ptr` are held (parking).
- Without `sw`: all state holds, including when a higher-priority master is requesting.
- The owner keeps the grant while it still requests and is the winner. Re-granting the same master does not change the outputs.
- Locked transfers (`HMASTLOCK`) and bursts in progress are visible only through `mst_can_switch` low. The arbiter needs no burst knowledge.
- Priority is sampled in the same cycle as `mst_HSEL`. A priority change without a switch point has no effect.

## Timing
- Reset (asynchronous, immediate): `master_granted`=0, `grant_valid`=0, `master_sel`=0, `rr_ptr`=MASTERS-1, so master 0 wins the first tie.
- Latency: a request at edge n with `sw` true produces a grant visible after edge n+1. All outputs are registered with no combinational input-to-output path.
- Back-to-back: the owner drops its request and another master requests in the same cycle → the new grant appears after the next edge. No idle cycle is inserted.
- `slv_HREADY` low stalls arbitration indefinitely and the grant is frozen.
- Owner `can_switch` low and `slv_HREADY` high: grant is held and competing requests wait.
- Reset asserted mid-transfer: grant is cleared at once. The next arbitration after release follows the reset values.
- MASTERS==1: winner is always 0, and the grant tracks `mst_HSEL` subject to `sw`.
- Invariant: `master_granted` is never multi-hot.

## Structure
- `ahb3lite_pkg` (shared): add `localparam` `HPRIO_MAX = 3'd7` and a `onehot2bin` function. The binary select and the master port's slave-select decode share that function.
- Sub-module `ahb3lite_interconnect_rr_pick` (combinational, parameter `N`): inputs `req[N]` and `ptr`; outputs `gnt` (one-hot) and `gnt_idx`. It implements the find-first-after-pointer search with wrap.
- The arbiter computes the max-priority mask and instantiates `rr_pick` on the masked requests.

## Test plan
- Reset → grant_valid=0, master_sel=0. Then MASTERS=3, only m1 requests at prio 2 with slv_HREADY=1 → master_granted=3'b010 one edge later.
- m0 prio 1 and m2 prio 5 request together, no owner → m2 granted. m2 drops its request → m0 granted on the next edge with no gap.
- m0, m1, m2 all at prio 3 and continuously requesting with can_switch=1 → grants rotate 0,1,2,0 over successive edges.
- m1 owns with can_switch=0 (locked burst) and m0 requests at prio 7 → m1 keeps the grant. can_switch goes to 1 → m0 granted after the following edge.
- Owner can_switch=1 but slv_HREADY=0 for 4 cycles while m2 requests → grant unchanged for 4 cycles, switches to m2 one edge after HREADY rises.
- Reset pulsed while m2 owns → master_granted=0 immediately, asynchronously. After release, m0 and m2 at equal prio → m0 wins.
